// File: rtl/free_list.sv
// rtl/free_list.sv - physical-register free list for 2-way rename/dispatch
// Circular FIFO of free pregs with speculative head, retire head and flush rollback.
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int DEPTH = NUM_PREGS - NUM_AREGS,
  localparam int AW = $clog2(DEPTH),
  localparam int PTRW = AW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            alloc_req,
  output logic [1:0][PW-1:0]    pdest_idx_out,
  output logic [1:0]            alloc_avail,
  input  logic [1:0]            retire_valid,
  input  logic [1:0][PW-1:0]    retire_told,
  input  logic                  flush,
  output logic [PTRW-1:0]       free_count
);

  logic [PW-1:0]   fifo_mem [DEPTH];
  logic [PTRW-1:0] head_q;
  logic [PTRW-1:0] tail_q;
  logic [PTRW-1:0] rhead_q;

  logic [PTRW-1:0] head_n;
  logic [PTRW-1:0] tail_n;
  logic [PTRW-1:0] rhead_n;

  logic [1:0]      grant;
  logic [1:0]      n_pop;
  logic [1:0]      n_push_raw;
  logic [1:0]      n_push;
  logic [PTRW:0]   fill_after;
  logic            push_ok;
  logic [AW-1:0]   head_idx;
  logic [AW-1:0]   tail_idx;
  logic [AW-1:0]   widx1;
  logic            we0;
  logic            we1;

  assign head_idx   = head_q[AW-1:0];
  assign tail_idx   = tail_q[AW-1:0];
  assign free_count = tail_q - head_q;

  assign alloc_avail[0] = (free_count != '0);
  assign alloc_avail[1] = (free_count > PTRW'(1));

  // Candidates come straight from registered state; same-cycle pushes are never bypassed.
  assign pdest_idx_out[0] = fifo_mem[head_idx];
  assign pdest_idx_out[1] = fifo_mem[head_idx + AW'(1)];

  // Flush squashes this cycle's allocations entirely.
  assign grant = alloc_req & alloc_avail & {2{~flush}};
  assign n_pop = {1'b0, grant[0]} + {1'b0, grant[1]};

  assign n_push_raw = {1'b0, retire_valid[0]} + {1'b0, retire_valid[1]};
  assign fill_after = {1'b0, free_count} + (PTRW+1)'(n_push_raw);
  assign push_ok    = (fill_after <= (PTRW+1)'(DEPTH));
  assign n_push     = push_ok ? n_push_raw : 2'b00;

  // The second told lands right after the first valid one, keeping slot order.
  assign we0   = retire_valid[0] & push_ok;
  assign we1   = retire_valid[1] & push_ok;
  assign widx1 = tail_idx + AW'(retire_valid[0]);

  assign tail_n  = tail_q + PTRW'(n_push);
  assign rhead_n = rhead_q + PTRW'(n_push);
  assign head_n  = flush ? rhead_n : (head_q + PTRW'(n_pop));

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= PTRW'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= PW'(NUM_AREGS + i);
      end
    end else begin
      head_q  <= head_n;
      rhead_q <= rhead_n;
      tail_q  <= tail_n;
      if (we0) fifo_mem[tail_idx] <= retire_told[0];
      if (we1) fifo_mem[widx1]    <= retire_told[1];
    end
  end

  no_overflow_push: assert property (@(posedge clock) disable iff (reset)
    (retire_valid != 2'b00) |-> push_ok);

  alloc_compacted: assert property (@(posedge clock) disable iff (reset)
    alloc_req != 2'b10);

  retire_compacted: assert property (@(posedge clock) disable iff (reset)
    retire_valid != 2'b10);

  head_before_tail: assert property (@(posedge clock) disable iff (reset)
    (tail_q - head_q) <= PTRW'(DEPTH));

  rhead_before_head: assert property (@(posedge clock) disable iff (reset)
    (head_q - rhead_q) <= PTRW'(DEPTH));

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - scoreboard bench for free_list against a queue-based rename model
// The model tracks free, in-flight and architectural preg sets; a monitor compares every cycle.
module tb_free_list;
  localparam int PW = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       alloc_req = 2'b00;
  logic [1:0][PW-1:0] pdest_idx_out;
  logic [1:0]       alloc_avail;
  logic [1:0]       retire_valid = 2'b00;
  logic [1:0][PW-1:0] retire_told = '0;
  logic             flush = 1'b0;
  logic [5:0]       free_count;

  typedef struct {
    int fc;
    int av;
    int p0;
    int p1;
  } exp_t;

  exp_t exp_q[$];
  int   free_m[$];
  int   spec_m[$];
  int   arch_m[$];
  int   checks = 0;
  int   failures = 0;
  int   total_pushes = 0;
  exp_t mon_e;

  always #5 clock = ~clock;

  free_list dut (
    .clock         (clock),
    .reset         (reset),
    .alloc_req     (alloc_req),
    .pdest_idx_out (pdest_idx_out),
    .alloc_avail   (alloc_avail),
    .retire_valid  (retire_valid),
    .retire_told   (retire_told),
    .flush         (flush),
    .free_count    (free_count)
  );

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    free_m.delete();
    spec_m.delete();
    arch_m.delete();
    for (int i = 0; i < 32; i++) begin
      arch_m.push_back(i);
      free_m.push_back(32 + i);
    end
  endtask

  task automatic arch_remove(input int v);
    for (int i = 0; i < arch_m.size(); i++) begin
      if (arch_m[i] == v) begin
        arch_m.delete(i);
        break;
      end
    end
  endtask

  // One clock of stimulus; the model advances and the expected post-edge view is queued.
  task automatic step(input bit rst, input logic [1:0] areq, input int nret,
                      input int t0, input int t1, input bit fl);
    exp_t e;
    int   sz;
    int   npop;
    @(negedge clock);
    reset           = rst;
    alloc_req       = areq;
    flush           = fl;
    retire_valid    = (nret == 2) ? 2'b11 : (nret == 1) ? 2'b01 : 2'b00;
    retire_told[0]  = PW'(t0);
    retire_told[1]  = PW'(t1);
    if (rst) begin
      model_reset();
    end else begin
      sz   = free_m.size();
      npop = 0;
      if (!fl) begin
        for (int k = 0; k < 2; k++) if (areq[k] && sz > k) npop++;
      end
      for (int k = 0; k < npop; k++) spec_m.push_back(free_m.pop_front());
      for (int k = 0; k < nret; k++) begin
        arch_remove(k == 0 ? t0 : t1);
        arch_m.push_back(spec_m.pop_front());
        free_m.push_back(k == 0 ? t0 : t1);
        total_pushes++;
      end
      if (fl) begin
        while (spec_m.size() > 0) free_m.push_front(spec_m.pop_back());
      end
    end
    e.fc = free_m.size();
    e.av = (e.fc > 1) ? 3 : (e.fc > 0) ? 1 : 0;
    e.p0 = (e.fc > 0) ? free_m[0] : -1;
    e.p1 = (e.fc > 1) ? free_m[1] : -1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 0, 0, 0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("free_count", int'(free_count), mon_e.fc);
        check("alloc_avail", int'(alloc_avail), mon_e.av);
        if (mon_e.p0 >= 0) check("pdest0", int'(pdest_idx_out[0]), mon_e.p0);
        if (mon_e.p1 >= 0) check("pdest1", int'(pdest_idx_out[1]), mon_e.p1);
      end
    end
  end

  initial begin
    logic [1:0] areq;
    int         nret;
    int         maxret;
    int         i0;
    int         i1;
    bit         fl;
    model_reset();

    step(1'b1, 2'b00, 0, 0, 0, 1'b0);
    idle(2);

    for (int c = 0; c < 18; c++) step(1'b0, 2'b11, 0, 0, 0, 1'b0);

    step(1'b0, 2'b00, 2, 7, 5, 1'b0);
    idle(1);

    step(1'b1, 2'b00, 0, 0, 0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 2'b11, 0, 0, 0, 1'b0);
    step(1'b0, 2'b00, 2, 3, 4, 1'b0);
    step(1'b0, 2'b00, 0, 0, 0, 1'b1);
    idle(1);

    step(1'b1, 2'b00, 0, 0, 0, 1'b0);
    for (int c = 0; c < 2; c++) step(1'b0, 2'b11, 0, 0, 0, 1'b0);
    step(1'b0, 2'b11, 1, 9, 0, 1'b1);
    idle(1);

    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       areq = 2'b00;
        1:       areq = 2'b01;
        default: areq = 2'b11;
      endcase
      maxret = (spec_m.size() < 2) ? spec_m.size() : 2;
      nret   = $urandom_range(0, maxret);
      fl     = ($urandom_range(0, 31) == 0);
      i0     = $urandom_range(0, arch_m.size() - 1);
      i1     = (i0 + 1 + $urandom_range(0, arch_m.size() - 2)) % arch_m.size();
      step(c == 1500, areq, nret, arch_m[i0], arch_m[i1], fl);
    end
    idle(2);

    repeat (3) @(posedge clock);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
